frame_loader: RTL and testbench
===============================

Name: frame_loader

Overview:
- Writer side of the 160x120 8-bit grayscale image memory that the display path reads through the zoom engines.
- Accepts a pixel stream (raster order, row-major) over a valid/ready handshake and generates write strobes, linear addresses and pixel coordinates for the framebuffer.
- Double-buffered: writes go to one bank while the display reads the other. Banks swap only when a complete frame has been loaded.

Parameters:
- IMG_WIDTH, 160, pixels per row
- IMG_HEIGHT, 120, rows per frame
- PIX_W, 8, pixel width in bits
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT) = 15, linear address width within one bank

Ports:
- clk  in  1  core clock (100 MHz domain)
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin loading a frame
- abort  in  1  cancel the frame in progress
- in_data  in  PIX_W  stream pixel
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a beat this cycle (registered)
- wr_en  out  1  write strobe to the image memory
- wr_addr  out  ADDR_W+1  {bank, linear address}
- wr_data  out  PIX_W  pixel to write
- wr_x  out  $clog2(IMG_WIDTH)  column of the current write
- wr_y  out  $clog2(IMG_HEIGHT)  row of the current write
- disp_bank  out  1  bank the display must read; equals ~write bank
- busy  out  1  frame load in progress
- done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (synchronous, overrides everything):
  - state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_x=0, wr_y=0, busy=0, done=0.
  - write bank=0, so disp_bank=1.
- FSM states: IDLE, LOAD, FINISH.
- IDLE:
  - in_ready=0.
  - start=1 and abort=0 → LOAD. At that edge: x, y and the linear counter clear to 0; busy=1 and in_ready=1 from the next cycle.
  - start and abort both high: abort wins and the loader stays in IDLE.
- LOAD, beat accepted (in_valid && in_ready):
  - At the next edge, for one cycle: wr_en=1, wr_data=in_data, wr_x=x, wr_y=y, wr_addr={bank, lin}.
  - Latency from accept to write strobe is 1 cycle.
  - The linear address comes from a running counter, not a multiplier: lin increments by 1 per beat.
  - x wraps from IMG_WIDTH-1 to 0 and increments y.
- LOAD, no beat: wr_en=0 the next cycle. in_valid while in_ready=0 is ignored and produces no write.
- Last beat (x=IMG_WIDTH-1, y=IMG_HEIGHT-1) accepted:
  - in_ready=0 from the next cycle, so no beat IMG_WIDTH*IMG_HEIGHT+1 is ever accepted.
  - The last write is emitted with lin=IMG_WIDTH*IMG_HEIGHT-1; state → FINISH.
- FINISH (one cycle):
  - At the exit edge: done=1 for exactly one cycle, bank toggles (disp_bank flips the same cycle), busy=0, → IDLE.
  - done is asserted the cycle after the last wr_en.
- abort in LOAD:
  - Next cycle: IDLE, in_ready=0, busy=0; no done and no bank toggle.
  - A beat presented in the abort cycle is not written.
  - A write already registered from the previous cycle still completes.
- start while busy: ignored.
- abort in IDLE or FINISH: ignored. FINISH always completes.
- Reset mid-load: the partial frame is discarded, bank returns to 0 and no done is generated.
- Counters never exceed IMG_WIDTH-1, IMG_HEIGHT-1 or IMG_WIDTH*IMG_HEIGHT-1.

Decomposition:
- Shared package img_pkg:
  - IMG_WIDTH, IMG_HEIGHT, PIX_W, ADDR_W, X_W=$clog2(IMG_WIDTH), Y_W=$clog2(IMG_HEIGHT).
  - FSM state encoding (IDLE/LOAD/FINISH); the display-side modules reuse the geometry constants.
- One sub-module, raster_addr_counter: clear/advance inputs; x, y and lin outputs; a last flag.
- The FSM, handshake, output registers and bank toggle stay in frame_loader.

Test Plan:
- Continuous in_valid, 19200 beats after start:
  - 19200 wr_en pulses with wr_addr 0..19199 in bank 0.
  - Last write x=159, y=119; done pulses 1 cycle after it; disp_bank 1→0.
  - in_ready=0 after the last beat; beat 19201 is not written.
- Row wrap: beat 159 → wr_x=159, wr_y=0, lin=159; beat 160 → wr_x=0, wr_y=1, lin=160.
- Random in_valid gaps (~30% duty):
  - Write addresses stay contiguous with no duplicates or skips.
  - wr_data matches the stream order; wr_en never fires without an accepted beat.
- abort asserted with beat 5000 presented:
  - Beat 5000 is not written; no done; disp_bank unchanged.
  - A following start restarts at lin=0, x=0, y=0 in the same bank.
- start pulsed at beat 100 while busy: no restart and addresses continue at 101. start and abort together in IDLE: loader stays in IDLE.
- reset asserted at beat 8000: next cycle all outputs are 0, bank=0 (disp_bank=1), busy=0, and no done.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image geometry and loader state encoding used by the frame loader
// and the display-side zoom engines.
package img_pkg;

  localparam int IMG_WIDTH    = 160;
  localparam int IMG_HEIGHT   = 120;
  localparam int PIX_W        = 8;
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W       = $clog2(FRAME_PIXELS);
  localparam int X_W          = $clog2(IMG_WIDTH);
  localparam int Y_W          = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } load_state_t;

endpackage

// File: rtl/raster_addr_counter.sv
// Raster-order position tracker: column, row and linear address advance
// together so the linear address never needs a multiplier.
module raster_addr_counter
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] lin,
  output logic              last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_W'(IMG_WIDTH - 1));
  assign y_end = (y == Y_W'(IMG_HEIGHT - 1));
  assign last  = x_end && y_end;

  // Saturate on the final pixel so the counters stay inside the frame.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x   <= '0;
      y   <= '0;
      lin <= '0;
    end else if (advance && !last) begin
      lin <= lin + ADDR_W'(1);
      if (x_end) begin
        x <= '0;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Double-buffered framebuffer writer: turns a raster pixel stream into write
// strobes, addresses and coordinates, swapping banks after each full frame.
module frame_loader
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [ADDR_W:0]  wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic [X_W-1:0]   wr_x,
  output logic [Y_W-1:0]   wr_y,
  output logic             disp_bank,
  output logic             busy,
  output logic             done
);

  load_state_t       state;
  load_state_t       state_next;
  logic              bank;
  logic              accept;
  logic              clear_cnt;
  logic              ready_next;
  logic              busy_next;
  logic              done_next;
  logic              bank_flip;
  logic [X_W-1:0]    cur_x;
  logic [Y_W-1:0]    cur_y;
  logic [ADDR_W-1:0] cur_lin;
  logic              cur_last;

  // A beat offered in the same cycle as abort is dropped.
  assign accept    = in_valid && in_ready && (state == LOAD) && !abort;
  assign disp_bank = ~bank;

  raster_addr_counter u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_cnt),
    .advance (accept),
    .x       (cur_x),
    .y       (cur_y),
    .lin     (cur_lin),
    .last    (cur_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !abort) state_next = LOAD;
      LOAD: begin
        if (abort)                    state_next = IDLE;
        else if (accept && cur_last)  state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clear_cnt  = (state == IDLE) && start && !abort;
    ready_next = (state_next == LOAD);
    busy_next  = (state_next != IDLE);
    done_next  = (state == FINISH);
    bank_flip  = (state == FINISH);
  end

  // Registered outputs; the write strobe trails the accepted beat by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bank     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_x     <= '0;
      wr_y     <= '0;
    end else begin
      in_ready <= ready_next;
      busy     <= busy_next;
      done     <= done_next;
      wr_en    <= accept;
      if (bank_flip) begin
        bank <= ~bank;
      end
      if (accept) begin
        wr_addr <= {bank, cur_lin};
        wr_data <= in_data;
        wr_x    <= cur_x;
        wr_y    <= cur_y;
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Directed self-checking bench for frame_loader: full frame, row wrap,
// gapped stream with abort, start-while-busy, restart and mid-load reset.
module tb_frame_loader;
  import img_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [PIX_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             wr_en;
  logic [ADDR_W:0]  wr_addr;
  logic [PIX_W-1:0] wr_data;
  logic [X_W-1:0]   wr_x;
  logic [Y_W-1:0]   wr_y;
  logic             disp_bank;
  logic             busy;
  logic             done;

  int   total = 0;
  int   bad   = 0;
  int   m_lin;
  logic m_bank;
  logic m_ready;
  int   cyc;

  always #5 clk = ~clk;

  frame_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .disp_bank (disp_bank),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] pix(input int n);
    return 8'((n * 7 + 3) & 255);
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One stream cycle: offer a beat, then check the write the model expects.
  task automatic drive_beat(input logic v, input logic s);
    logic       acc;
    logic [7:0] d;
    d = pix(m_lin);
    check_output("in_ready", in_ready, m_ready);
    in_valid = v;
    in_data  = d;
    start    = s;
    acc      = v && m_ready;
    step();
    in_valid = 1'b0;
    start    = 1'b0;
    if (acc) begin
      check_output("write", {wr_en, wr_addr, wr_data, wr_x, wr_y, done},
                   {1'b1, m_bank, 15'(m_lin), d, 8'(m_lin % 160), 7'(m_lin / 160), 1'b0});
      m_lin++;
      if (m_lin == FRAME_PIXELS) m_ready = 1'b0;
    end else begin
      check_output("no_write", {wr_en, done}, 2'b00);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    m_lin    = 0;
    m_bank   = 1'b0;
    m_ready  = 1'b0;
    step();
    step();
    check_output("reset_outs", {in_ready, wr_en, wr_addr, wr_data, wr_x, wr_y, busy, done}, 64'd0);
    check_output("reset_disp_bank", disp_bank, 1'b1);
    reset = 1'b0;

    // start and abort together: abort wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_idle", {busy, in_ready}, 2'b00);
    step();
    check_output("start_abort_stay", {busy, in_ready, wr_en}, 3'b000);

    // full frame, continuous valid, start pulsed again at beat 100
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("start_busy", {busy, in_ready, done}, 3'b110);
    m_ready = 1'b1;
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      drive_beat(1'b1, i == 100);
      if (i == 159) check_output("wrap_159", {wr_x, wr_y, wr_addr}, {8'd159, 7'd0, 16'd159});
      if (i == 160) check_output("wrap_160", {wr_x, wr_y, wr_addr}, {8'd0, 7'd1, 16'd160});
    end
    check_output("last_write", {wr_en, wr_x, wr_y, wr_addr}, {1'b1, 8'd159, 7'd119, 16'd19199});
    check_output("ready_low_after_last", in_ready, 1'b0);
    check_output("busy_in_finish", {busy, done}, 2'b10);
    check_output("disp_bank_before_swap", disp_bank, 1'b1);
    in_valid = 1'b1;
    in_data  = pix(FRAME_PIXELS);
    step();
    in_valid = 1'b0;
    check_output("done_pulse", {done, wr_en}, 2'b10);
    check_output("disp_bank_swap", disp_bank, 1'b0);
    check_output("busy_clear", busy, 1'b0);
    step();
    check_output("done_one_cycle", {done, wr_en, in_ready}, 3'b000);
    m_bank = 1'b1;

    // gapped stream into bank 1, aborted with beat 5000 presented
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("start2_busy", {busy, in_ready}, 2'b11);
    m_lin   = 0;
    m_ready = 1'b1;
    cyc     = 0;
    while (m_lin < 5000 && cyc < 40000) begin
      drive_beat($urandom_range(0, 9) < 3, 1'b0);
      cyc++;
    end
    check_output("gap_budget", m_lin >= 5000, 1'b1);
    check_output("ready_before_abort", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = pix(5000);
    abort    = 1'b1;
    step();
    in_valid = 1'b0;
    abort    = 1'b0;
    m_ready  = 1'b0;
    check_output("abort_outs", {wr_en, in_ready, busy, done}, 4'b0000);
    check_output("abort_bank", disp_bank, 1'b0);
    step();
    check_output("abort_no_done", {done, wr_en, busy}, 3'b000);
    check_output("abort_bank_hold", disp_bank, 1'b0);

    // restart in the same bank, then reset with beat 8000 presented
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("restart_busy", {busy, in_ready}, 2'b11);
    m_lin   = 0;
    m_ready = 1'b1;
    drive_beat(1'b1, 1'b0);
    check_output("restart_first", {wr_addr, wr_x, wr_y}, {1'b1, 15'd0, 8'd0, 7'd0});
    for (int i = 1; i < 8000; i++) drive_beat(1'b1, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = pix(8000);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    check_output("reset_mid_outs", {in_ready, wr_en, wr_addr, wr_data, wr_x, wr_y, busy, done}, 64'd0);
    check_output("reset_mid_bank", disp_bank, 1'b1);
    step();
    check_output("reset_mid_quiet", {done, busy, wr_en, in_ready}, 4'b0000);
    check_output("reset_mid_bank_hold", disp_bank, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
